// File: rtl/tla_pkg.sv
// Shared types and defaults for the 200 MHz gate responder slice.
package tla_pkg;

    localparam int WDIS_W_DEF = 3;
    localparam int PLUS_W_DEF = 32;

    // Level of cap_mode that selects the capture parameter set
    localparam logic CAP_MODE = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } tla_state_e;

endpackage

// File: rtl/tla_gate_resp_200_if.sv
// Command/parameter/status bundle between the control side and the 200 MHz gate responder.
interface tla_gate_resp_200_if
    import tla_pkg::*;
#(
    parameter int WDIS_W = WDIS_W_DEF,
    parameter int PLUS_W = PLUS_W_DEF
);
    logic              Ga_cap_mode;
    logic [WDIS_W-1:0] Ga_cap_wdis;
    logic [PLUS_W-1:0] Ga_cap_plus;
    logic [WDIS_W-1:0] Ga_com_wdis;
    logic [PLUS_W-1:0] Ga_com_plus;
    logic              Ga_com_open;
    logic              Ga_com_close;
    logic              Ga_gate;
    logic              Ga_gate_sof;
    logic              Ga_gate_eof;
    logic              Ga_abort;
    logic              Ga_busy;
    logic [WDIS_W-1:0] Ga_wdis;
    logic              Ga_err;

    modport master (
        output Ga_cap_mode, Ga_cap_wdis, Ga_cap_plus, Ga_com_wdis, Ga_com_plus,
               Ga_com_open, Ga_com_close,
        input  Ga_gate, Ga_gate_sof, Ga_gate_eof, Ga_abort, Ga_busy, Ga_wdis, Ga_err
    );

    modport slave (
        input  Ga_cap_mode, Ga_cap_wdis, Ga_cap_plus, Ga_com_wdis, Ga_com_plus,
               Ga_com_open, Ga_com_close,
        output Ga_gate, Ga_gate_sof, Ga_gate_eof, Ga_abort, Ga_busy, Ga_wdis, Ga_err
    );

endinterface

// File: rtl/tla_edge_det.sv
// Single-bit rising-edge detector; the history register samples every clock.
module tla_edge_det (
    input  logic Ga_clk200,
    input  logic Ga_rst_n,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge Ga_clk200 or negedge Ga_rst_n) begin
        if (!Ga_rst_n) prev <= 1'b0;
        else           prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/tla_gate_resp_200.sv
// Counted acquisition gate driven by crossed open/close command pulses.
// Optional macro TLA_RETRIG_EN: open while a window runs restarts it with fresh parameters.
//
// state | meaning
// IDLE  | no window; waiting for an open edge
// OPEN  | gate high, counting up to the latched length
module tla_gate_resp_200
    import tla_pkg::*;
#(
    parameter int WDIS_W = WDIS_W_DEF,
    parameter int PLUS_W = PLUS_W_DEF
) (
    input  logic Ga_clk200,
    input  logic Ga_rst_n,
    tla_gate_resp_200_if.slave bus
);

    logic              open_rise, close_rise, retrig, last_cyc;
    tla_state_e        state;
    logic [PLUS_W-1:0] cnt, plus_l, sel_plus;
    logic [WDIS_W-1:0] wdis_l, sel_wdis, wdis_q;
    logic              sof_q, abort_q, err_q;

    tla_edge_det u_open_det (
        .Ga_clk200 (Ga_clk200),
        .Ga_rst_n  (Ga_rst_n),
        .d         (bus.Ga_com_open),
        .rise      (open_rise)
    );

    tla_edge_det u_close_det (
        .Ga_clk200 (Ga_clk200),
        .Ga_rst_n  (Ga_rst_n),
        .d         (bus.Ga_com_close),
        .rise      (close_rise)
    );

    assign sel_plus = (bus.Ga_cap_mode == CAP_MODE) ? bus.Ga_cap_plus : bus.Ga_com_plus;
    assign sel_wdis = (bus.Ga_cap_mode == CAP_MODE) ? bus.Ga_cap_wdis : bus.Ga_com_wdis;

`ifdef TLA_RETRIG_EN
    assign retrig = (state == OPEN) && open_rise && !close_rise;
`else
    assign retrig = 1'b0;
`endif

    assign last_cyc = (state == OPEN) && (cnt == plus_l - PLUS_W'(1));

    always_ff @(posedge Ga_clk200 or negedge Ga_rst_n) begin
        if (!Ga_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            plus_l  <= '0;
            wdis_l  <= '0;
            wdis_q  <= '0;
            sof_q   <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sof_q   <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (open_rise && !close_rise) begin
                        if (sel_plus != '0) begin
                            state  <= OPEN;
                            cnt    <= '0;
                            plus_l <= sel_plus;
                            wdis_l <= sel_wdis;
                            sof_q  <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
                OPEN: begin
                    // Close outranks both retrigger and normal completion
                    if (close_rise) begin
                        state   <= IDLE;
                        abort_q <= 1'b1;
                    end else if (retrig) begin
                        if (sel_plus != '0) begin
                            cnt    <= '0;
                            plus_l <= sel_plus;
                            wdis_l <= sel_wdis;
                            sof_q  <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            abort_q <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end else if (last_cyc) begin
                        state  <= IDLE;
                        wdis_q <= wdis_l;
                    end else begin
                        cnt <= cnt + PLUS_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Ga_gate     = (state == OPEN);
    assign bus.Ga_busy     = (state == OPEN);
    assign bus.Ga_gate_sof = sof_q;
    assign bus.Ga_gate_eof = last_cyc && !close_rise && !retrig;
    assign bus.Ga_abort    = abort_q;
    assign bus.Ga_wdis     = wdis_q;
    assign bus.Ga_err      = err_q;

endmodule

// File: tb/tb_tla_gate_resp_200.sv
// Bench for tla_gate_resp_200: directed and randomized windows against a window-level model.
module tb_tla_gate_resp_200;

`ifdef TLA_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_asrt;
    int   n_fail;
    logic [2:0] exp_wdis;
    logic       exp_err;

    tla_gate_resp_200_if bus ();

    tla_gate_resp_200 dut (
        .Ga_clk200 (clk),
        .Ga_rst_n  (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asrt++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_params(input bit m, input logic [2:0] wd, input int p);
        bus.Ga_cap_mode = m;
        if (m) begin
            bus.Ga_cap_wdis = wd;
            bus.Ga_cap_plus = 32'(p);
            bus.Ga_com_wdis = 3'($urandom_range(0, 7));
            bus.Ga_com_plus = 32'($urandom_range(1, 40));
        end else begin
            bus.Ga_com_wdis = wd;
            bus.Ga_com_plus = 32'(p);
            bus.Ga_cap_wdis = 3'($urandom_range(0, 7));
            bus.Ga_cap_plus = 32'($urandom_range(1, 40));
        end
    endtask

    task automatic scramble();
        bus.Ga_cap_mode = 1'($urandom_range(0, 1));
        bus.Ga_cap_wdis = 3'($urandom_range(0, 7));
        bus.Ga_cap_plus = 32'($urandom_range(0, 40));
        bus.Ga_com_wdis = 3'($urandom_range(0, 7));
        bus.Ga_com_plus = 32'($urandom_range(0, 40));
    endtask

    // Open rises in cycle 0 (held open_len cycles); close rises in cycle g (-1: none);
    // a second 1-cycle open rises in cycle r (-1: none). Gate cycle n is cycle n.
    task automatic run_window(input string tag, input bit m1, input logic [2:0] wd1, input int p1,
                              input int open_len, input int g, input int close_len,
                              input int r, input bit m2, input logic [2:0] wd2, input int p2);
        int last, eof_at, abort_at, sof1, sof2, err_at, kmax;
        bit upd;
        logic [2:0] new_wd;
        last = 0; eof_at = -1; abort_at = -1; sof1 = -1; sof2 = -1; err_at = -1;
        upd = 1'b0; new_wd = wd1;
        if (g == 0) begin
            last = 0;
        end else if (p1 == 0) begin
            err_at = 1;
        end else begin
            sof1 = 1; last = p1; eof_at = p1; upd = 1'b1;
            if (RETRIG && r >= 1 && r <= last && (g < 0 || g > r)) begin
                if (p2 == 0) begin
                    last = r; abort_at = r + 1; eof_at = -1; upd = 1'b0; err_at = r + 1;
                end else begin
                    last = r + p2; eof_at = last; sof2 = r + 1; new_wd = wd2;
                end
            end
            if (g >= 1 && g <= last) begin
                last = g; abort_at = g + 1; upd = 1'b0;
                if (eof_at >= g) eof_at = -1;
                if (sof2 > g) sof2 = -1;
            end
        end
        kmax = last;
        if (g + close_len > kmax) kmax = g + close_len;
        if (open_len > kmax) kmax = open_len;
        if (r + 1 > kmax) kmax = r + 1;
        kmax = kmax + 3;

        for (int k = 0; k <= kmax; k++) begin
            @(posedge clk); #1;
            bus.Ga_com_open  = (k < open_len) || (r >= 1 && k == r);
            bus.Ga_com_close = (g >= 0 && k >= g && k < g + close_len);
            if (k == 0)      set_params(m1, wd1, p1);
            else if (k == r) set_params(m2, wd2, p2);
            else             scramble();
            @(negedge clk);
            chk($sformatf("%s.gate@%0d", tag, k), 32'(bus.Ga_gate), 32'(k >= 1 && k <= last));
            chk($sformatf("%s.busy@%0d", tag, k), 32'(bus.Ga_busy), 32'(k >= 1 && k <= last));
            chk($sformatf("%s.sof@%0d", tag, k), 32'(bus.Ga_gate_sof), 32'(k == sof1 || k == sof2));
            chk($sformatf("%s.eof@%0d", tag, k), 32'(bus.Ga_gate_eof), 32'(k == eof_at));
            chk($sformatf("%s.abort@%0d", tag, k), 32'(bus.Ga_abort), 32'(k == abort_at));
            chk($sformatf("%s.err@%0d", tag, k), 32'(bus.Ga_err),
                32'(exp_err || (err_at >= 0 && k >= err_at)));
            chk($sformatf("%s.wdis@%0d", tag, k), 32'(bus.Ga_wdis),
                32'((upd && k > last) ? new_wd : exp_wdis));
        end
        if (upd) exp_wdis = new_wd;
        if (err_at >= 0) exp_err = 1'b1;
    endtask

    initial begin
        int p, g, cl, ol;
        n_asrt = 0; n_fail = 0; exp_wdis = '0; exp_err = 1'b0;
        bus.Ga_com_open = 1'b0; bus.Ga_com_close = 1'b0;
        set_params(1'b1, 3'd0, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.gate", 32'(bus.Ga_gate), 32'd0);
        chk("rst.sof", 32'(bus.Ga_gate_sof), 32'd0);
        chk("rst.eof", 32'(bus.Ga_gate_eof), 32'd0);
        chk("rst.abort", 32'(bus.Ga_abort), 32'd0);
        chk("rst.wdis", 32'(bus.Ga_wdis), 32'd0);
        chk("rst.err", 32'(bus.Ga_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_window("cap10", 1'b1, 3'd5, 10, 3, -1, 1, -1, 1'b0, 3'd0, 0);
        run_window("com1", 1'b0, 3'd2, 1, 1, -1, 1, -1, 1'b0, 3'd0, 0);
        run_window("close6", 1'b1, 3'd6, 20, 2, 6, 2, -1, 1'b0, 3'd0, 0);
        run_window("simul_idle", 1'b1, 3'd4, 5, 1, 0, 1, -1, 1'b0, 3'd0, 0);
        run_window("simul_open", 1'b0, 3'd3, 10, 1, 3, 1, 3, 1'b1, 3'd1, 4);
        run_window("retrig", 1'b1, 3'd1, 8, 1, -1, 1, 4, 1'b0, 3'd7, 3);
        if (RETRIG) run_window("retrig0", 1'b0, 3'd2, 8, 1, -1, 1, 3, 1'b1, 3'd5, 0);

        for (int i = 0; i < 25; i++) begin
            p  = $urandom_range(1, 12);
            ol = $urandom_range(1, 3);
            cl = $urandom_range(1, 3);
            g  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, p + 2) : -1;
            run_window($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       p, ol, g, cl, -1, 1'b0, 3'd0, 0);
        end

        run_window("zero", 1'b1, 3'd3, 0, 2, -1, 1, -1, 1'b0, 3'd0, 0);
        run_window("after_zero", 1'b0, 3'd6, 4, 1, -1, 1, -1, 1'b0, 3'd0, 0);

        // Reset asserted mid-cycle during the first gate cycle
        @(posedge clk); #1;
        bus.Ga_com_open = 1'b1;
        set_params(1'b1, 3'd3, 20);
        @(posedge clk); #1;
        bus.Ga_com_open = 1'b0;
        @(negedge clk);
        chk("rstmid.gate_before", 32'(bus.Ga_gate), 32'd1);
        chk("rstmid.sof_before", 32'(bus.Ga_gate_sof), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid.gate", 32'(bus.Ga_gate), 32'd0);
        chk("rstmid.sof", 32'(bus.Ga_gate_sof), 32'd0);
        chk("rstmid.eof", 32'(bus.Ga_gate_eof), 32'd0);
        chk("rstmid.abort", 32'(bus.Ga_abort), 32'd0);
        chk("rstmid.err", 32'(bus.Ga_err), 32'd0);
        chk("rstmid.wdis", 32'(bus.Ga_wdis), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_wdis = '0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid.gate_after", 32'(bus.Ga_gate), 32'd0);
        chk("rstmid.abort_after", 32'(bus.Ga_abort), 32'd0);
        run_window("post_rst", 1'b1, 3'd4, 3, 1, -1, 1, -1, 1'b0, 3'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
